ifm_scan_ctrl: RTL
==================

// Module: ifm_scan_ctrl
// PURPOSE
//  Sequencer for the 3x3 IFM window buffer feeding the PE array. Walks a stride-1
//  3x3 window over an HxW input feature map in snake order, issues IFM memory
//  fetches, drives the buffer's ifm_read/mode codes, and offers each loaded window
//  to the PE array with a valid/ready handshake. Sits between the top-level
//  layer FSM, IFM SRAM read port and IFM window buffer.
// PARAMETERS
//  DIM_W    8      width of feature-map dimension/coordinate fields
//  CNT_W    16     width of optional stall counter
// PORTS
//  clk          in   1      clock
//  rst_n        in   1      async active-low reset
//  start        in   1      1-cycle pulse; latch cfg_*, begin scan (ignored when busy)
//  abort        in   1      sync abort; return to IDLE next cycle, no done
//  cfg_mode     in   2      2'b01 CONVOL, 2'b10 FULLY; others illegal
//  cfg_width    in   DIM_W  IFM width W (pixels)
//  cfg_height   in   DIM_W  IFM height H (pixels)
//  mem_rd_en    out  1      IFM SRAM read strobe; data valid at buffer input next cycle
//  mem_rd_kind  out  3      fetch shape: 111 ALL(3 rows), 001 right col, 010 bottom row, 100 left col
//  mem_row      out  DIM_W  row of first new pixel of fetch
//  mem_col      out  DIM_W  column of first new pixel of fetch
//  buf_read     out  3      window buffer ifm_read code (101 NO_CHANGE when not shifting)
//  buf_mode     out  2      window buffer mode; latched cfg_mode when busy, 2'b00 otherwise
//  win_valid    out  1      current window stable in buffer, offered to PE array
//  win_ready    in   1      PE array accepts window
//  win_row      out  DIM_W  top-left row of offered window
//  win_col      out  DIM_W  top-left column of offered window
//  busy         out  1      high from accepted start until DONE
//  done         out  1      1-cycle pulse after last window accepted
//  cfg_err      out  1      1-cycle pulse: illegal mode or W<3 or H<3; no scan started
//  stall_cnt    out  CNT_W  WAIT cycles with win_ready low (see CONFIGURATION)
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0 except buf_read=3'b101; buf_mode=0, counters 0.
//  OW=W-2, OH=H-2 computed on start. Window (r,c), r in 0..OH-1, c in 0..OW-1.
//  Order: (0,0) ALL; even rows move RIGHT to c=OW-1; odd rows move LEFT to c=0; DOWN at row end.
//  States: IDLE -> FETCH -> SHIFT -> WAIT -> (FETCH | DONE) -> IDLE.
//   IDLE : start & legal cfg -> FETCH, busy=1; start & illegal -> cfg_err pulse, stay IDLE.
//   FETCH: mem_rd_en=1 one cycle, mem_rd_kind=next move. Addresses: ALL (r,c);
//          RIGHT to (r,c+1): (r,c+3); DOWN to (r+1,c): (r+3,c); LEFT to (r,c-1): (r,c-1).
//   SHIFT: buf_read=move code one cycle (aligned with SRAM data); window coords update.
//   WAIT : win_valid=1, win_row/col stable until win_valid&win_ready. On handshake:
//          last window (r=OH-1, c=OW-1 if OH-1 even else 0) -> DONE, else FETCH.
//   DONE : done=1 one cycle, busy=0 next, buf_mode=0 -> IDLE.
//  Latency: start at T0 -> mem_rd_en T1 -> buf_read T2 -> win_valid T3. Min 3 cycles/window.
//  Boundaries: OW=1 -> only DOWN moves; OH=1 -> only RIGHT moves; W=H=3 -> single ALL window.
//  win_valid never drops without handshake except on abort/reset.
//  abort wins over every state incl. same-cycle handshake; clears busy/win_valid, buf_mode=0.
//  start during busy ignored; start and abort same cycle in IDLE: abort wins, stay IDLE.
//  cfg_* sampled only on accepted start; later changes have no effect.
//  Async reset mid-scan: immediate return to reset values; no done.
// CONFIGURATION
//  STALL_CNT_EN defined: stall_cnt counts WAIT cycles with win_ready=0, cleared on
//   accepted start, saturates at all-ones, holds after done.
//  STALL_CNT_EN undefined: stall_cnt tied to 0, no counter logic.
// TESTING
//  W=3,H=3,CONVOL, win_ready=1 -> kinds {ALL}; one window (0,0); done at T4.
//  W=5,H=4,ready=1 -> kinds ALL,R,R,D,L,L; windows (0,0)(0,1)(0,2)(1,2)(1,1)(1,0); 6 handshakes, done.
//  W=3,H=5 -> ALL,D,D; mem_row 0,3,4; mem_col 0; windows (0,0)(1,0)(2,0).
//  W=2 or cfg_mode=2'b11 -> cfg_err pulse, busy stays 0, no mem_rd_en.
//  W=5,H=4, win_ready low 4 cycles on window 2 -> win_valid/coords held; stall_cnt=4 with STALL_CNT_EN.
//  abort during 3rd WAIT -> IDLE next cycle, buf_read=101, buf_mode=0, no done; new start rescans from (0,0).

Source files
------------

// File: rtl/ifm_scan_if.sv
// Control/data bundle between the IFM scan sequencer and its neighbours
// (layer FSM, IFM SRAM read port, window buffer, PE array).
interface ifm_scan_if #(
  parameter int unsigned DIM_W = 8,
  parameter int unsigned CNT_W = 16
);
  logic             start;
  logic             abort;
  logic [1:0]       cfg_mode;
  logic [DIM_W-1:0] cfg_width;
  logic [DIM_W-1:0] cfg_height;
  logic             mem_rd_en;
  logic [2:0]       mem_rd_kind;
  logic [DIM_W-1:0] mem_row;
  logic [DIM_W-1:0] mem_col;
  logic [2:0]       buf_read;
  logic [1:0]       buf_mode;
  logic             win_valid;
  logic             win_ready;
  logic [DIM_W-1:0] win_row;
  logic [DIM_W-1:0] win_col;
  logic             busy;
  logic             done;
  logic             cfg_err;
  logic [CNT_W-1:0] stall_cnt;

  // Sequencer side
  modport master (
    input  start, abort, cfg_mode, cfg_width, cfg_height, win_ready,
    output mem_rd_en, mem_rd_kind, mem_row, mem_col, buf_read, buf_mode,
           win_valid, win_row, win_col, busy, done, cfg_err, stall_cnt
  );

  // Environment side (layer FSM / memory / buffer / PE array)
  modport slave (
    output start, abort, cfg_mode, cfg_width, cfg_height, win_ready,
    input  mem_rd_en, mem_rd_kind, mem_row, mem_col, buf_read, buf_mode,
           win_valid, win_row, win_col, busy, done, cfg_err, stall_cnt
  );
endinterface

// File: rtl/ifm_scan_ctrl.sv
// Snake-order 3x3 window sequencer for the IFM window buffer.
// Optional macro STALL_CNT_EN enables the WAIT-stall counter on stall_cnt.
module ifm_scan_ctrl #(
  parameter int unsigned DIM_W = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  ifm_scan_if.master bus
);

  localparam logic [2:0] MV_ALL   = 3'b111;
  localparam logic [2:0] MV_RIGHT = 3'b001;
  localparam logic [2:0] MV_DOWN  = 3'b010;
  localparam logic [2:0] MV_LEFT  = 3'b100;
  localparam logic [2:0] RD_HOLD  = 3'b101;
  localparam logic [1:0] MODE_CONVOL = 2'b01;
  localparam logic [1:0] MODE_FULLY  = 2'b10;
  localparam logic [1:0] MODE_OFF    = 2'b00;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_SHIFT,
    S_WAIT,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [DIM_W-1:0] ow_q, ow_d;
  logic [DIM_W-1:0] oh_q, oh_d;
  logic [DIM_W-1:0] row_q, row_d;
  logic [DIM_W-1:0] col_q, col_d;
  logic             mem_rd_en_q, mem_rd_en_d;
  logic [2:0]       mem_rd_kind_q, mem_rd_kind_d;
  logic [DIM_W-1:0] mem_row_q, mem_row_d;
  logic [DIM_W-1:0] mem_col_q, mem_col_d;
  logic [2:0]       buf_read_q, buf_read_d;
  logic [1:0]       buf_mode_q, buf_mode_d;
  logic             win_valid_q, win_valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             cfg_err_q, cfg_err_d;

  logic             cfg_legal_c;
  logic             start_ok_c;
  logic             last_c;
  logic [2:0]       nxt_move_c;

  // Configuration legality and the snake-order successor of the current window
  always_comb begin
    cfg_legal_c = ((bus.cfg_mode == MODE_CONVOL) || (bus.cfg_mode == MODE_FULLY)) &&
                  (bus.cfg_width >= DIM_W'(3)) && (bus.cfg_height >= DIM_W'(3));
    start_ok_c  = (state_q == S_IDLE) && bus.start && !bus.abort && cfg_legal_c;
    if (row_q[0]) begin
      last_c     = (row_q == oh_q - DIM_W'(1)) && (col_q == '0);
      nxt_move_c = (col_q != '0) ? MV_LEFT : MV_DOWN;
    end else begin
      last_c     = (row_q == oh_q - DIM_W'(1)) && (col_q == ow_q - DIM_W'(1));
      nxt_move_c = (col_q != ow_q - DIM_W'(1)) ? MV_RIGHT : MV_DOWN;
    end
  end

  // Next-state and registered-output decode
  always_comb begin
    state_d       = state_q;
    ow_d          = ow_q;
    oh_d          = oh_q;
    row_d         = row_q;
    col_d         = col_q;
    mem_rd_en_d   = 1'b0;
    mem_rd_kind_d = mem_rd_kind_q;
    mem_row_d     = mem_row_q;
    mem_col_d     = mem_col_q;
    buf_read_d    = RD_HOLD;
    buf_mode_d    = buf_mode_q;
    win_valid_d   = 1'b0;
    busy_d        = busy_q;
    done_d        = 1'b0;
    cfg_err_d     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start_ok_c) begin
          state_d       = S_FETCH;
          ow_d          = bus.cfg_width - DIM_W'(2);
          oh_d          = bus.cfg_height - DIM_W'(2);
          busy_d        = 1'b1;
          buf_mode_d    = bus.cfg_mode;
          mem_rd_en_d   = 1'b1;
          mem_rd_kind_d = MV_ALL;
          mem_row_d     = '0;
          mem_col_d     = '0;
        end else if (bus.start) begin
          cfg_err_d = 1'b1;
        end
      end

      S_FETCH: begin
        state_d    = S_SHIFT;
        buf_read_d = mem_rd_kind_q;
        unique case (mem_rd_kind_q)
          MV_RIGHT: col_d = col_q + DIM_W'(1);
          MV_LEFT:  col_d = col_q - DIM_W'(1);
          MV_DOWN:  row_d = row_q + DIM_W'(1);
          default: begin
            row_d = '0;
            col_d = '0;
          end
        endcase
      end

      S_SHIFT: begin
        state_d     = S_WAIT;
        win_valid_d = 1'b1;
      end

      S_WAIT: begin
        if (!bus.win_ready) begin
          win_valid_d = 1'b1;
        end else if (last_c) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          state_d       = S_FETCH;
          mem_rd_en_d   = 1'b1;
          mem_rd_kind_d = nxt_move_c;
          // Address of the first pixel entering the window after the move
          unique case (nxt_move_c)
            MV_RIGHT: begin
              mem_row_d = row_q;
              mem_col_d = col_q + DIM_W'(3);
            end
            MV_LEFT: begin
              mem_row_d = row_q;
              mem_col_d = col_q - DIM_W'(1);
            end
            default: begin
              mem_row_d = row_q + DIM_W'(3);
              mem_col_d = col_q;
            end
          endcase
        end
      end

      S_DONE: begin
        state_d    = S_IDLE;
        busy_d     = 1'b0;
        buf_mode_d = MODE_OFF;
      end

      default: begin
        state_d    = S_IDLE;
        busy_d     = 1'b0;
        buf_mode_d = MODE_OFF;
      end
    endcase

    // Abort overrides everything, including a same-cycle handshake
    if (bus.abort) begin
      state_d     = S_IDLE;
      busy_d      = 1'b0;
      buf_mode_d  = MODE_OFF;
      mem_rd_en_d = 1'b0;
      buf_read_d  = RD_HOLD;
      win_valid_d = 1'b0;
      done_d      = 1'b0;
      cfg_err_d   = 1'b0;
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      ow_q          <= '0;
      oh_q          <= '0;
      row_q         <= '0;
      col_q         <= '0;
      mem_rd_en_q   <= 1'b0;
      mem_rd_kind_q <= '0;
      mem_row_q     <= '0;
      mem_col_q     <= '0;
      buf_read_q    <= RD_HOLD;
      buf_mode_q    <= MODE_OFF;
      win_valid_q   <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      cfg_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      ow_q          <= ow_d;
      oh_q          <= oh_d;
      row_q         <= row_d;
      col_q         <= col_d;
      mem_rd_en_q   <= mem_rd_en_d;
      mem_rd_kind_q <= mem_rd_kind_d;
      mem_row_q     <= mem_row_d;
      mem_col_q     <= mem_col_d;
      buf_read_q    <= buf_read_d;
      buf_mode_q    <= buf_mode_d;
      win_valid_q   <= win_valid_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      cfg_err_q     <= cfg_err_d;
    end
  end

  assign bus.mem_rd_en   = mem_rd_en_q;
  assign bus.mem_rd_kind = mem_rd_kind_q;
  assign bus.mem_row     = mem_row_q;
  assign bus.mem_col     = mem_col_q;
  assign bus.buf_read    = buf_read_q;
  assign bus.buf_mode    = buf_mode_q;
  assign bus.win_valid   = win_valid_q;
  assign bus.win_row     = row_q;
  assign bus.win_col     = col_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.cfg_err     = cfg_err_q;

`ifdef STALL_CNT_EN
  logic [CNT_W-1:0] stall_q, stall_d;

  // Saturating count of WAIT cycles the PE array held off the handshake
  always_comb begin
    stall_d = stall_q;
    if (start_ok_c) begin
      stall_d = '0;
    end else if ((state_q == S_WAIT) && !bus.win_ready && (stall_q != {CNT_W{1'b1}})) begin
      stall_d = stall_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign bus.stall_cnt = stall_q;
`else
  assign bus.stall_cnt = CNT_W'(0);
`endif

endmodule
